// File: rtl/rggen_mux_pipeline.sv
// Registered one-hot read-data mux with valid/ready on both sides, select-legality
// flagging and a saturating select-error counter. SKID=1 gives a registered o_ready.
module rggen_mux_pipeline #(
    parameter int WIDTH             = 1,
    parameter int ENTRIES           = 2,
    parameter int SKID              = 1,
    parameter int ERROR_COUNT_WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [ENTRIES-1:0]           i_select,
    input  logic [WIDTH*ENTRIES-1:0]     i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_select_error,
    input  logic                         i_clear_error,
    output logic [ERROR_COUNT_WIDTH-1:0] o_error_count
);

    logic [WIDTH-1:0]             mux_data;
    logic                         mux_error;
    logic                         up_accept;
    logic [WIDTH-1:0]             out_data_q;
    logic                         out_error_q;
    logic                         out_valid_q;
    logic [ERROR_COUNT_WIDTH-1:0] err_count_q;
    logic [ERROR_COUNT_WIDTH-1:0] err_count_d;

    generate
        if (ENTRIES == 1) begin : g_single
            assign mux_data  = i_data;
            assign mux_error = ~i_select[0];
        end else begin : g_multi
            always_comb begin
                logic seen;
                logic multi;
                mux_data = '0;
                seen     = 1'b0;
                multi    = 1'b0;
                for (int k = 0; k < ENTRIES; k++) begin
                    mux_data = mux_data | (i_data[WIDTH*k +: WIDTH] & {WIDTH{i_select[k]}});
                    multi    = multi | (seen & i_select[k]);
                    seen     = seen | i_select[k];
                end
                mux_error = ~seen | multi;
            end
        end
    endgenerate

    assign up_accept = i_valid & o_ready;

    generate
        if (SKID != 0) begin : g_skid
            // state | meaning
            // EMPTY | nothing buffered, output idle
            // ONE   | output register holds the head item
            // FULL  | output and skid register both hold items, upstream stalled
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_FULL  = 2'd2
            } state_e;

            state_e           state_q;
            logic [WIDTH-1:0] skid_data_q;
            logic             skid_error_q;
            logic             ready_q;
            logic             down_drain;

            assign down_drain = out_valid_q & i_ready;
            assign o_ready    = ready_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    state_q      <= ST_EMPTY;
                    out_data_q   <= '0;
                    out_error_q  <= 1'b0;
                    out_valid_q  <= 1'b0;
                    skid_data_q  <= '0;
                    skid_error_q <= 1'b0;
                    ready_q      <= 1'b1;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (up_accept) begin
                                out_data_q  <= mux_data;
                                out_error_q <= mux_error;
                                out_valid_q <= 1'b1;
                                state_q     <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (up_accept && down_drain) begin
                                out_data_q  <= mux_data;
                                out_error_q <= mux_error;
                            end else if (down_drain) begin
                                out_valid_q <= 1'b0;
                                state_q     <= ST_EMPTY;
                            end else if (up_accept) begin
                                skid_data_q  <= mux_data;
                                skid_error_q <= mux_error;
                                ready_q      <= 1'b0;
                                state_q      <= ST_FULL;
                            end
                        end
                        ST_FULL: begin
                            if (down_drain) begin
                                out_data_q  <= skid_data_q;
                                out_error_q <= skid_error_q;
                                ready_q     <= 1'b1;
                                state_q     <= ST_ONE;
                            end
                        end
                        default: begin
                            out_valid_q <= 1'b0;
                            ready_q     <= 1'b1;
                            state_q     <= ST_EMPTY;
                        end
                    endcase
                end
            end
        end else begin : g_single_stage
            assign o_ready = ~out_valid_q | i_ready;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    out_data_q  <= '0;
                    out_error_q <= 1'b0;
                    out_valid_q <= 1'b0;
                end else if (up_accept) begin
                    out_data_q  <= mux_data;
                    out_error_q <= mux_error;
                    out_valid_q <= 1'b1;
                end else if (i_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    endgenerate

    // Clear wins over a same-cycle errored accept.
    always_comb begin
        err_count_d = err_count_q;
        if (i_clear_error) begin
            err_count_d = '0;
        end else if (up_accept && mux_error && !(&err_count_q)) begin
            err_count_d = err_count_q + ERROR_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign o_valid        = out_valid_q;
    assign o_data         = out_data_q;
    assign o_select_error = out_error_q;
    assign o_error_count  = err_count_q;

endmodule
